seq_shift_add_multiplier: RTL

//  Parametrised sequential shift-add multiplier core (X:A:B datapath, counter, control FSM in one block).

---
 rtl/seq_shift_add_multiplier.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: X:A:B datapath, iteration counter and control FSM.
// One add+shift per cycle for WIDTH cycles; the product lands in {Aval,Bval}.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             last;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;

  // One extra bit keeps -(-2^(W-1)) representable on the final signed step.
  always_comb begin
    last   = (count_q == CW'(WIDTH - 1));
    s_ext  = {mode_q & sreg_q[WIDTH-1], sreg_q};
    addend = '0;
    if (b_q[0]) begin
      addend = (mode_q && last) ? -s_ext : s_ext;
    end
    sum = {x_q, a_q} + addend;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    mode_d  = mode_q;

    unique case (state_q)
      IDLE: begin
        if (ClearA_LoadB) begin
          x_d = 1'b0;
          a_d = '0;
          b_d = S;
        end else if (Run) begin
          sreg_d  = S;
          mode_d  = Signed_Mode;
          x_d     = 1'b0;
          a_d     = '0;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        b_d = {sum[0], b_q[WIDTH-1:1]};
        a_d = sum[WIDTH:1];
        x_d = mode_q ? sum[WIDTH] : 1'b0;
        if (last) begin
          state_d = HOLD;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      HOLD: begin
        if (ClearA_LoadB) begin
          x_d = 1'b0;
          a_d = '0;
          b_d = S;
        end else if (!Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == HOLD);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sreg_q  <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule
